// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation classes and the datapath mux select values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU decode: maps the FSM's ALU operation class and the instruction's
// funct fields onto the ALU control code.
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    // NOTE: assign every combinational output a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // op5 separates register sub from addi, whose bit 30 is immediate data
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences each instruction
// through the shared memory port and ALU and drives the datapath selects.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BNE_EN        = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic [2:0]         ALUControl,
    output logic               IllegalInstr,
    output logic [STATE_W-1:0] State
);

    state_t state, state_next;
    aluop_t aluop;
    logic   branch, pcupdate, taken, mem_done;

    assign mem_done = MemReady | (MEM_HANDSHAKE == 1'b0);
    assign taken    = (BNE_EN && funct3 == 3'b001) ? ~Zero : Zero;
    assign PCWrite  = (branch & taken) | pcupdate;
    assign State    = STATE_W'(state);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        aluop        = ALUOP_ADD;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        branch       = 1'b0;
        pcupdate     = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                IRWrite    = mem_done;
                pcupdate   = mem_done;
                state_next = mem_done ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECUTER;
                    OP_ITYPE:          state_next = EXECUTEI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    default: begin
                        IllegalInstr = 1'b1;
                        state_next   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = mem_done ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                state_next = mem_done ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                aluop      = ALUOP_FUNC;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNC;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                // OldPC + 4 flows through ALUOut into rd during ALUWB
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcupdate   = 1'b1;
                state_next = ALUWB;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

endmodule
